cfg_delay_line: RTL and testbench

- Multi-lane, valid-tagged delay line with runtime-selectable depth, stall (enable) and flush.
- Successor to the fixed 64-bit, fixed-depth delay register used to align operands across the force/integration pipeline.
- Lets one instance match the latency of any arithmetic stage by configuration, without re-elaboration.
- Carries a per-beat valid bit so bubbles propagate correctly.

---
 rtl/cfg_delay_line_pkg.sv | 22 ++
 rtl/cfg_delay_line_stage.sv | 33 +++
 rtl/cfg_delay_line.sv | 131 +++++++++++++
 tb/tb_cfg_delay_line.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cfg_delay_line_pkg.sv
// Shared types and helpers for the configurable delay line.
package delay_pkg;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_SHIFT,
    OP_FLUSH,
    OP_LOAD
  } op_e;

  function automatic int unsigned depth_width(input int unsigned max_depth);
    return $clog2(max_depth + 1);
  endfunction

  function automatic int unsigned clamp_depth(input int unsigned value,
                                              input int unsigned max_depth);
    if (value == 0) return 1;
    if (value > max_depth) return max_depth;
    return value;
  endfunction

endpackage

// File: rtl/cfg_delay_line_stage.sv
// One {valid, data} pipeline register; flush clears only the valid bit.
module delay_stage #(
  parameter int unsigned W = 192
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/cfg_delay_line.sv
// Valid-tagged multi-lane delay line with runtime depth, stall and flush.
module cfg_delay_line
  import delay_pkg::*;
#(
  parameter  int unsigned WIDTH         = 64,
  parameter  int unsigned LANES         = 3,
  parameter  int unsigned MAX_DEPTH     = 16,
  parameter  int unsigned DEFAULT_DEPTH = 4,
  localparam int unsigned DW            = depth_width(MAX_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in,
  input  logic [DW-1:0]          cfg_depth,
  input  logic                   cfg_load,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out,
  output logic [DW-1:0]          cur_depth,
  output logic [DW-1:0]          occupancy,
  output logic                   busy
);

  localparam int unsigned W = LANES * WIDTH;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] data;
  } stage_t;

  if (MAX_DEPTH < 1) begin : g_bad_max
    $error("MAX_DEPTH must be at least 1");
  end
  if (DEFAULT_DEPTH < 1 || DEFAULT_DEPTH > MAX_DEPTH) begin : g_bad_def
    $error("DEFAULT_DEPTH must be within 1..MAX_DEPTH");
  end

  op_e          w_op;
  logic         w_shift;
  logic         w_clr;
  logic         w_valid [MAX_DEPTH];
  logic [W-1:0] w_data  [MAX_DEPTH];
  stage_t       w_tap;
  logic [DW-1:0] r_depth;
  logic [DW-1:0] r_occ;
  logic [DW-1:0] w_popcnt;
  logic          r_new_depth;

  always_comb begin
    if (cfg_load)   w_op = OP_LOAD;
    else if (flush) w_op = OP_FLUSH;
    else if (en)    w_op = OP_SHIFT;
    else            w_op = OP_HOLD;
  end

  assign w_shift = (w_op == OP_SHIFT);
  assign w_clr   = (w_op == OP_LOAD) || (w_op == OP_FLUSH);

  for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      delay_stage #(.W(W)) u_stage (
        .i_clk(clk), .i_rst(rst), .i_en(w_shift), .i_flush(w_clr),
        .i_valid(in_valid), .i_data(in),
        .o_valid(w_valid[i]), .o_data(w_data[i])
      );
    end else begin : g_body
      delay_stage #(.W(W)) u_stage (
        .i_clk(clk), .i_rst(rst), .i_en(w_shift), .i_flush(w_clr),
        .i_valid(w_valid[i-1]), .i_data(w_data[i-1]),
        .o_valid(w_valid[i]), .o_data(w_data[i])
      );
    end
  end

  always_comb begin
    w_tap = '0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (r_depth == DW'(i + 1)) begin
        w_tap.valid = w_valid[i];
        w_tap.data  = w_data[i];
      end
    end
  end

  assign out_valid = w_tap.valid;
  assign out       = w_tap.valid ? w_tap.data : '0;

  always_ff @(posedge clk) begin
    if (rst)                 r_depth <= DW'(DEFAULT_DEPTH);
    else if (w_op == OP_LOAD) r_depth <= DW'(clamp_depth(32'(cfg_depth), MAX_DEPTH));
  end

  // Tracks beats in active stages: one enters with in_valid, one leaves via the tap.
  always_ff @(posedge clk) begin
    if (rst)          r_occ <= '0;
    else if (w_clr)   r_occ <= '0;
    else if (w_shift) r_occ <= r_occ + DW'(in_valid) - DW'(out_valid);
  end

  assign cur_depth = r_depth;
  assign occupancy = r_occ;
  assign busy      = (r_occ != '0);

  always_comb begin
    w_popcnt = '0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (DW'(i) < r_depth) w_popcnt = w_popcnt + DW'(w_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  r_new_depth <= 1'b0;
    else if (w_op == OP_LOAD) r_new_depth <= 1'b1;
    else if (out_valid)       r_new_depth <= 1'b0;
  end

  a_occ_popcnt: assert property (@(posedge clk) disable iff (rst) r_occ == w_popcnt);
  a_out_masked: assert property (@(posedge clk) disable iff (rst) out_valid || (out == '0));
  a_accept: assert property (@(posedge clk) disable iff (rst)
    w_shift |=> (w_valid[0] == $past(in_valid)));

  for (genvar i = 1; i < MAX_DEPTH; i++) begin : g_lat
    a_advance: assert property (@(posedge clk) disable iff (rst)
      w_shift |=> (w_valid[i] == $past(w_valid[i-1])));
  end

  c_new_depth_out: cover property (@(posedge clk) disable iff (rst) r_new_depth && out_valid);

endmodule

// File: tb/tb_cfg_delay_line.sv
// Directed bench with a transaction scoreboard keyed on enabled-edge count.
module tb_cfg_delay_line;

  localparam int unsigned WIDTH         = 64;
  localparam int unsigned LANES         = 3;
  localparam int unsigned MAX_DEPTH     = 16;
  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned DW            = 5;
  localparam int unsigned W             = LANES * WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in = '0;
  logic [DW-1:0] cfg_depth = '0;
  logic          cfg_load = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out;
  logic [DW-1:0] cur_depth;
  logic [DW-1:0] occupancy;
  logic          busy;

  typedef struct {
    logic [W-1:0] d;
    int           due;
  } beat_t;

  beat_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_en = 0;
  int unsigned m_depth = DEFAULT_DEPTH;

  always #5 clk = ~clk;

  cfg_delay_line #(
    .WIDTH(WIDTH), .LANES(LANES), .MAX_DEPTH(MAX_DEPTH), .DEFAULT_DEPTH(DEFAULT_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .in(in),
    .cfg_depth(cfg_depth), .cfg_load(cfg_load), .out_valid(out_valid), .out(out),
    .cur_depth(cur_depth), .occupancy(occupancy), .busy(busy)
  );

  function automatic logic [W-1:0] pat(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] c);
    return {c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic         exp_v;
    logic [W-1:0] exp_d;
    exp_v = (sb.size() > 0) && (sb[0].due == n_en);
    exp_d = '0;
    if (exp_v) exp_d = sb[0].d;
    chk("out_valid", W'(out_valid), W'(exp_v));
    chk("out", out, exp_d);
    chk("occupancy", W'(occupancy), W'(sb.size()));
    chk("busy", W'(busy), W'(sb.size() != 0));
    chk("cur_depth", W'(cur_depth), W'(m_depth));
  endtask

  task automatic cyc(input logic r, input logic e, input logic f, input logic l,
                     input logic [DW-1:0] c, input logic v, input logic [W-1:0] din);
    rst = r; en = e; flush = f; cfg_load = l; cfg_depth = c; in_valid = v; in = din;
    @(posedge clk);
    if (r) begin
      sb.delete();
      m_depth = DEFAULT_DEPTH;
    end else if (l) begin
      sb.delete();
      if (c == 0)              m_depth = 1;
      else if (c > MAX_DEPTH)  m_depth = MAX_DEPTH;
      else                     m_depth = int'(c);
    end else if (f) begin
      sb.delete();
    end else if (e) begin
      if (sb.size() > 0 && sb[0].due == n_en) sb.delete(0);
      n_en++;
      if (v) sb.push_back('{d: din, due: n_en + int'(m_depth) - 1});
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, pat(64'hdead, 64'hdead, 64'hdead));
  endtask

  task automatic beat(input logic [W-1:0] din);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, din);
  endtask

  task automatic load(input logic [DW-1:0] c);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, c, 1'b0, '0);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, pat(64'h9, 64'h9, 64'h9));

    // default depth 4: single beat
    beat(pat(64'h1, 64'h2, 64'h3));
    idle(6);

    // depth 7 stream, then clamp to 1 and to MAX_DEPTH
    load(5'd7);
    for (int i = 0; i < 10; i++) beat(pat(64'(i), 64'(i + 100), 64'(i + 200)));
    idle(9);
    load(5'd0);
    for (int i = 0; i < 5; i++) beat(pat(64'(i + 10), 64'h0, 64'hffff));
    idle(2);
    load(5'd20);
    for (int i = 0; i < 3; i++) beat(pat(64'(i + 20), 64'h5, 64'h6));
    idle(18);

    // stall mid-flight at depth 4
    load(5'd4);
    beat(pat(64'haaaa, 64'hbbbb, 64'hcccc));
    idle(1);
    stall(3);
    idle(4);

    // flush together with en and in_valid at depth 5
    load(5'd5);
    for (int i = 0; i < 3; i++) beat(pat(64'(i + 30), 64'h1, 64'h2));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1, pat(64'h77, 64'h77, 64'h77));
    idle(7);

    // flush while stalled
    beat(pat(64'h44, 64'h45, 64'h46));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    idle(6);

    // depth reload with two beats in flight
    beat(pat(64'h50, 64'h51, 64'h52));
    beat(pat(64'h53, 64'h54, 64'h55));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, pat(64'h66, 64'h66, 64'h66));
    idle(2);
    beat(pat(64'h60, 64'h61, 64'h62));
    idle(4);

    // reset during a stream
    load(5'd9);
    for (int i = 0; i < 5; i++) beat(pat(64'(i + 40), 64'h3, 64'h4));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, pat(64'h88, 64'h88, 64'h88));
    for (int i = 5; i < 10; i++) beat(pat(64'(i + 40), 64'h3, 64'h4));
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
